// File: rtl/fp_addsub_driver.sv
`default_nettype none
// ============================================================================
// fp_addsub_driver : single-outstanding AXI-Stream driver for the fpAddSub core
// Revision 1.0
// ============================================================================
module fp_addsub_driver #(
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1023,
  parameter int TIMEOUT_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  input  logic              req_sub_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_timeout_o,
  output logic              result_dropped_o,
  output logic              m_axis_a_tvalid_o,
  input  logic              m_axis_a_tready_i,
  output logic [DATA_W-1:0] m_axis_a_tdata_o,
  output logic              m_axis_b_tvalid_o,
  input  logic              m_axis_b_tready_i,
  output logic [DATA_W-1:0] m_axis_b_tdata_o,
  output logic              m_axis_operation_tvalid_o,
  input  logic              m_axis_operation_tready_i,
  output logic [7:0]        m_axis_operation_tdata_o,
  input  logic              s_axis_result_tvalid_i,
  output logic              s_axis_result_tready_o,
  input  logic [DATA_W-1:0] s_axis_result_tdata_i
);

  localparam logic [TIMEOUT_W-1:0] C_TIMEOUT = TIMEOUT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0]    C_QNAN    = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic                a_vld_q, a_vld_d, b_vld_q, b_vld_d, op_vld_q, op_vld_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                timeout_q, timeout_d;
  logic                dropped_q, dropped_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic w_a_done, w_b_done, w_op_done, w_res_hs;

  // A channel counts as sent once its tvalid is low or is being accepted now.
  assign w_a_done  = ~a_vld_q  | m_axis_a_tready_i;
  assign w_b_done  = ~b_vld_q  | m_axis_b_tready_i;
  assign w_op_done = ~op_vld_q | m_axis_operation_tready_i;
  assign w_res_hs  = s_axis_result_tvalid_i & s_axis_result_tready_o;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    a_vld_d     = a_vld_q;
    b_vld_d     = b_vld_q;
    op_vld_d    = op_vld_q;
    resp_data_d = resp_data_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    dropped_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          a_d      = req_a_i;
          b_d      = req_b_i;
          op_d     = req_sub_i;
          a_vld_d  = 1'b1;
          b_vld_d  = 1'b1;
          op_vld_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_axis_a_tready_i)         a_vld_d  = 1'b0;
        if (m_axis_b_tready_i)         b_vld_d  = 1'b0;
        if (m_axis_operation_tready_i) op_vld_d = 1'b0;
        if (w_a_done && w_b_done && w_op_done) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle takes priority.
        if (s_axis_result_tvalid_i) begin
          resp_data_d = s_axis_result_tdata_i;
          timeout_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == C_TIMEOUT) begin
          resp_data_d = C_QNAN;
          timeout_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_res_hs && (state_q != S_WAIT)) dropped_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      a_vld_q     <= 1'b0;
      b_vld_q     <= 1'b0;
      op_vld_q    <= 1'b0;
      resp_data_q <= '0;
      timeout_q   <= 1'b0;
      dropped_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      a_vld_q     <= a_vld_d;
      b_vld_q     <= b_vld_d;
      op_vld_q    <= op_vld_d;
      resp_data_q <= resp_data_d;
      timeout_q   <= timeout_d;
      dropped_q   <= dropped_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o               = (state_q == S_IDLE);
  assign resp_valid_o              = (state_q == S_RESP);
  assign resp_data_o               = resp_data_q;
  assign resp_timeout_o            = timeout_q;
  assign result_dropped_o          = dropped_q;
  assign m_axis_a_tvalid_o         = a_vld_q;
  assign m_axis_a_tdata_o          = a_q;
  assign m_axis_b_tvalid_o         = b_vld_q;
  assign m_axis_b_tdata_o          = b_q;
  assign m_axis_operation_tvalid_o = op_vld_q;
  assign m_axis_operation_tdata_o  = {7'b0, op_q};
  assign s_axis_result_tready_o    = (state_q != S_ISSUE);

endmodule
`default_nettype wire
